ori_hist_ctrl: RTL

Orientation-histogram controller for the descriptor/orientation stage. It accepts a window of gradient samples, each an 8-bit quantized direction address plus a magnitude. For each sample it drives the shared combinational direction LUT (8-bit address → 5-bit bin, 32 bins, wrapping) and accumulates the magnitude into the returned bin. After the window completes, it streams the 32 bins out under valid/ready handshake.

---
 rtl/ori_hist_pkg.sv | 27 ++
 rtl/ori_hist_acc.sv | 42 ++++
 rtl/ori_hist_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ori_hist_pkg.sv
// Shared definitions for the orientation-histogram controller: bin geometry,
// FSM states and the saturating adder used by the accumulator bank.
package ori_hist_pkg;

  localparam int NUM_BINS = 32;
  localparam int BIN_W    = 5;
  localparam int ROM_AW   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Operands stay well below bit 63, so the raw sum carries into at most one
  // extra bit before being clamped to the w-bit maximum.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int w);
    logic [63:0] max_v;
    logic [63:0] sum;
    max_v = (64'd1 << w) - 64'd1;
    sum   = a + b;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/ori_hist_acc.sv
// 32-entry saturating accumulator bank: synchronous clear, one read-modify-write
// port per cycle and a combinational read port.
module ori_hist_acc
  import ori_hist_pkg::*;
#(
  parameter int MAG_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [BIN_W-1:0] wr_bin,
  input  logic [MAG_W-1:0] wr_mag,
  input  logic [BIN_W-1:0] rd_bin,
  output logic [ACC_W-1:0] rd_val
);

  logic [ACC_W-1:0] acc_q [NUM_BINS];
  logic [ACC_W-1:0] acc_d [NUM_BINS];

  // Whole RMW happens in one cycle, so consecutive hits on one bin chain naturally.
  always_comb begin
    for (int i = 0; i < NUM_BINS; i++) acc_d[i] = acc_q[i];
    if (clr) begin
      for (int i = 0; i < NUM_BINS; i++) acc_d[i] = '0;
    end else if (wr_en) begin
      acc_d[wr_bin] = ACC_W'(sat_add(64'(acc_q[wr_bin]), 64'(wr_mag), ACC_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BINS; i++) acc_q[i] <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign rd_val = acc_q[rd_bin];

endmodule

// File: rtl/ori_hist_ctrl.sv
// Orientation-histogram controller: accumulates a window of gradient samples
// into 32 direction bins via an external LUT, then streams the bins out.
module ori_hist_ctrl
  import ori_hist_pkg::*;
#(
  parameter int MAG_W     = 16,
  parameter int ACC_W     = 24,
  parameter int N_SAMPLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROM_AW-1:0] in_addr,
  input  logic [MAG_W-1:0]  in_mag,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [BIN_W-1:0]  rom_spo,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [BIN_W-1:0]  hist_bin,
  output logic [ACC_W-1:0]  hist_val,
  output logic              hist_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               drain_q, drain_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               done_q, done_d;
  logic               s1_valid_q, s1_valid_d;
  logic [ROM_AW-1:0]  s1_addr_q, s1_addr_d;
  logic [MAG_W-1:0]   s1_mag_q, s1_mag_d;
  logic               s2_valid_q, s2_valid_d;
  logic [BIN_W-1:0]   s2_bin_q, s2_bin_d;
  logic [MAG_W-1:0]   s2_mag_q, s2_mag_d;
  logic               accept, xfer, acc_clr;
  logic [ACC_W-1:0]   rd_val;

  // Both streams use valid/ready: a beat moves on a rising edge where valid and
  // ready are both high; the producer holds its payload stable until then.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    drain_d    = drain_q;
    bin_d      = bin_q;
    done_d     = 1'b0;
    acc_clr    = 1'b0;
    in_ready   = (state_q == ST_ACCUM) && (count_q < CNT_W'(N_SAMPLES));
    hist_valid = (state_q == ST_OUT);
    accept     = in_valid && in_ready;
    xfer       = hist_valid && hist_ready;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          count_d = '0;
          acc_clr = 1'b1;
        end
      end
      ST_ACCUM: begin
        drain_d = 1'b0;
        if (accept) begin
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(N_SAMPLES - 1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_OUT;
          bin_d   = '0;
        end
      end
      ST_OUT: begin
        if (xfer) begin
          bin_d = bin_q + 1'b1;
          if (bin_q == BIN_W'(NUM_BINS - 1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // S1 captures on accept; S2 latches the LUT answer for the S1 address.
    s1_valid_d = accept;
    s1_addr_d  = accept ? in_addr : s1_addr_q;
    s1_mag_d   = accept ? in_mag : s1_mag_q;
    s2_valid_d = s1_valid_q;
    s2_bin_d   = s1_valid_q ? rom_spo : s2_bin_q;
    s2_mag_d   = s1_valid_q ? s1_mag_q : s2_mag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      drain_q    <= 1'b0;
      bin_q      <= '0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_mag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_mag_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      bin_q      <= bin_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_mag_q   <= s1_mag_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
      s2_mag_q   <= s2_mag_d;
    end
  end

  ori_hist_acc #(
    .MAG_W(MAG_W),
    .ACC_W(ACC_W)
  ) u_acc (
    .clk   (clk),
    .rst   (rst),
    .clr   (acc_clr),
    .wr_en (s2_valid_q),
    .wr_bin(s2_bin_q),
    .wr_mag(s2_mag_q),
    .rd_bin(bin_q),
    .rd_val(rd_val)
  );

  assign rom_a     = s1_addr_q;
  assign hist_bin  = bin_q;
  assign hist_val  = hist_valid ? rd_val : '0;
  assign hist_last = hist_valid && (bin_q == BIN_W'(NUM_BINS - 1));
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule
